// File: rtl/ppu_oam_dma_if.sv
// Bus bundle for the sprite DMA engine: CPU write snoop, CPU-space memory read port and
// the PPU register interface. The DMA engine is the master; the surrounding system is the slave.
`timescale 1ns/1ps

interface ppu_oam_dma_if;
   logic [15:0] cpu_a_in;
   logic        cpu_r_nw_in;
   logic [7:0]  cpu_d_in;
   logic [7:0]  mem_d_in;
   logic        rdy_out;
   logic        dma_active_out;
   logic [15:0] dma_a_out;
   logic        dma_r_nw_out;
   logic [2:0]  ri_sel_out;
   logic        ri_ncs_out;
   logic        ri_r_nw_out;
   logic [7:0]  ri_d_out;

   modport master (
      input  cpu_a_in, cpu_r_nw_in, cpu_d_in, mem_d_in,
      output rdy_out, dma_active_out, dma_a_out, dma_r_nw_out,
      output ri_sel_out, ri_ncs_out, ri_r_nw_out, ri_d_out
   );

   modport slave (
      output cpu_a_in, cpu_r_nw_in, cpu_d_in, mem_d_in,
      input  rdy_out, dma_active_out, dma_a_out, dma_r_nw_out,
      input  ri_sel_out, ri_ncs_out, ri_r_nw_out, ri_d_out
   );
endinterface

// File: rtl/ppu_oam_dma.sv
// Sprite OAM DMA engine. A CPU write of page P to DMA_REG_ADDR halts the CPU and copies
// P00-PFF into the PPU OAMDATA register, one READ/WRITE cycle pair per byte.
// Optional feature macro: OAM_DMA_ODD_ALIGN_EN (inserts a PAD cycle when the free-running
// parity bit is 1 during ALIGN).
`timescale 1ns/1ps

module ppu_oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter logic [2:0]  OAMDATA_SEL  = 3'h4
) (
   input logic            clk_in,
   input logic            nrst_in,
   ppu_oam_dma_if.master  bus_io
);

   typedef enum logic [2:0] {StIdle, StAlign, StPad, StRead, StWrite} state_e;

   state_e      state_q;
   logic        hit_q;
   logic [7:0]  page_q;
   logic [7:0]  cnt_q;
   logic        rdy_q;
   logic        active_q;
   logic [15:0] dma_a_q;
   logic [2:0]  ri_sel_q;
   logic        ri_ncs_q;
   logic        ri_r_nw_q;
   logic [7:0]  ri_d_q;
`ifdef OAM_DMA_ODD_ALIGN_EN
   logic        parity_q;
`endif

   logic hit;
   logic start;

   // A held write must not retrigger, so only the rising edge of a hit starts a run.
   assign hit   = (bus_io.cpu_a_in == DMA_REG_ADDR) && !bus_io.cpu_r_nw_in;
   assign start = hit && !hit_q;

   // Transfer sequencer with registered bus outputs.
   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state_q   <= StIdle;
         hit_q     <= 1'b0;
         page_q    <= 8'h00;
         cnt_q     <= 8'h00;
         rdy_q     <= 1'b1;
         active_q  <= 1'b0;
         dma_a_q   <= 16'h0000;
         ri_sel_q  <= 3'h0;
         ri_ncs_q  <= 1'b1;
         ri_r_nw_q <= 1'b1;
         ri_d_q    <= 8'h00;
`ifdef OAM_DMA_ODD_ALIGN_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         hit_q <= hit;
`ifdef OAM_DMA_ODD_ALIGN_EN
         parity_q <= ~parity_q;
`endif
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  page_q  <= bus_io.cpu_d_in;
                  cnt_q   <= 8'h00;
                  rdy_q   <= 1'b0;
                  state_q <= StAlign;
               end
            end
            StAlign: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
               if (parity_q) begin
                  state_q <= StPad;
               end else begin
                  active_q <= 1'b1;
                  dma_a_q  <= {page_q, cnt_q};
                  state_q  <= StRead;
               end
`else
               active_q <= 1'b1;
               dma_a_q  <= {page_q, cnt_q};
               state_q  <= StRead;
`endif
            end
            StPad: begin
               active_q <= 1'b1;
               dma_a_q  <= {page_q, cnt_q};
               state_q  <= StRead;
            end
            StRead: begin
               // Memory data for the address presented this cycle is settled by this edge.
               ri_d_q    <= bus_io.mem_d_in;
               ri_ncs_q  <= 1'b0;
               ri_sel_q  <= OAMDATA_SEL;
               ri_r_nw_q <= 1'b0;
               state_q   <= StWrite;
            end
            StWrite: begin
               ri_ncs_q  <= 1'b1;
               ri_r_nw_q <= 1'b1;
               if (cnt_q == 8'hFF) begin
                  rdy_q    <= 1'b1;
                  active_q <= 1'b0;
                  state_q  <= StIdle;
               end else begin
                  // 8-bit increment: the address never carries into the next page.
                  cnt_q   <= cnt_q + 8'd1;
                  dma_a_q <= {page_q, cnt_q + 8'd1};
                  state_q <= StRead;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.rdy_out        = rdy_q;
   assign bus_io.dma_active_out = active_q;
   assign bus_io.dma_a_out      = dma_a_q;
   assign bus_io.dma_r_nw_out   = 1'b1;
   assign bus_io.ri_sel_out     = ri_sel_q;
   assign bus_io.ri_ncs_out     = ri_ncs_q;
   assign bus_io.ri_r_nw_out    = ri_r_nw_q;
   assign bus_io.ri_d_out       = ri_d_q;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Directed bench for ppu_oam_dma: reset values, full page copies, page FF wrap, edge
// trigger, mid-transfer reset and (with OAM_DMA_ODD_ALIGN_EN) parity padding.
`timescale 1ns/1ps

module tb_ppu_oam_dma;

   logic clk  = 1'b0;
   logic nrst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   ppu_oam_dma_if bus ();

   ppu_oam_dma dut (
      .clk_in  (clk),
      .nrst_in (nrst),
      .bus_io  (bus)
   );

   always #5 clk = ~clk;

   // Memory image: page 02 holds i ^ 5A; other pages are distinct so a wrong page shows up.
   function automatic logic [7:0] exp_data(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
   endfunction

   assign bus.mem_d_in = exp_data(bus.dma_a_out);

`ifdef OAM_DMA_ODD_ALIGN_EN
   logic tb_par;
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) tb_par <= 1'b0;
      else       tb_par <= ~tb_par;
   end
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue a write of page to 4014 held for hold clocks, then watch until rdy returns high.
   // Must be entered just after a falling clock edge.
   task automatic run_xfer(input logic [7:0] page, input int hold, input int abort_at,
                           output int rdy_low, output int exp_low, output int strobes,
                           output int bad, output logic [15:0] first_a,
                           output logic [15:0] last_a, output int zero_seen,
                           output int stray, output int timeout);
      logic        seen;
      logic [15:0] ea;
      rdy_low = 0; exp_low = 513; strobes = 0; bad = 0; first_a = '0; last_a = '0;
      zero_seen = 0; stray = 0; timeout = 1; seen = 1'b0;
      bus.cpu_a_in    = 16'h4014;
      bus.cpu_r_nw_in = 1'b0;
      bus.cpu_d_in    = page;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (!bus.rdy_out) begin
`ifdef OAM_DMA_ODD_ALIGN_EN
            if (!seen) exp_low = 513 + int'(tb_par);
`endif
            seen = 1'b1;
            rdy_low++;
         end
         if (bus.dma_active_out && bus.dma_a_out == 16'h0000) zero_seen++;
         if (!bus.ri_ncs_out) begin
            ea = {page, strobes[7:0]};
            if (bus.rdy_out) stray++;
            if (bus.dma_a_out !== ea || bus.ri_d_out !== exp_data(ea) ||
                bus.ri_sel_out !== 3'h4 || bus.ri_r_nw_out !== 1'b0 ||
                bus.dma_active_out !== 1'b1 || bus.dma_r_nw_out !== 1'b1) bad++;
            if (strobes == 0) first_a = bus.dma_a_out;
            last_a = bus.dma_a_out;
            strobes++;
            if (abort_at > 0 && strobes == abort_at) begin
               timeout = 0;
               return;
            end
         end
         if (cyc + 1 >= hold) begin
            bus.cpu_a_in    = 16'h0000;
            bus.cpu_r_nw_in = 1'b1;
         end
         if (seen && bus.rdy_out && cyc >= hold + 4) begin
            timeout = 0;
            return;
         end
      end
      bus.cpu_a_in    = 16'h0000;
      bus.cpu_r_nw_in = 1'b1;
   endtask

   // Full transfer with checks; want_low of 0 takes the bench's own low-time model.
   task automatic do_xfer(input string tag, input logic [7:0] page, input int hold,
                          input int want_low);
      int rdy_low, exp_low, strobes, bad, zero_seen, stray, timeout;
      logic [15:0] first_a, last_a;
      run_xfer(page, hold, 0, rdy_low, exp_low, strobes, bad, first_a, last_a, zero_seen,
               stray, timeout);
      if (want_low != 0) exp_low = want_low;
      check_eq({tag, ".timeout"},   timeout,  0);
      check_eq({tag, ".rdy_low"},   rdy_low,  exp_low);
      check_eq({tag, ".strobes"},   strobes,  256);
      check_eq({tag, ".bad_strb"},  bad,      0);
      check_eq({tag, ".first_a"},   first_a,  {page, 8'h00});
      check_eq({tag, ".last_a"},    last_a,   {page, 8'hFF});
      check_eq({tag, ".addr_wrap"}, zero_seen, 0);
      check_eq({tag, ".stray"},     stray,    0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, ".rdy"},      bus.rdy_out,        1'b1);
      check_eq({tag, ".active"},   bus.dma_active_out, 1'b0);
      check_eq({tag, ".dma_a"},    bus.dma_a_out,      16'h0000);
      check_eq({tag, ".dma_r_nw"}, bus.dma_r_nw_out,   1'b1);
      check_eq({tag, ".ri_sel"},   bus.ri_sel_out,     3'h0);
      check_eq({tag, ".ri_ncs"},   bus.ri_ncs_out,     1'b1);
      check_eq({tag, ".ri_r_nw"},  bus.ri_r_nw_out,    1'b1);
      check_eq({tag, ".ri_d"},     bus.ri_d_out,       8'h00);
   endtask

   initial begin
      int rdy_low, exp_low, strobes, bad, zero_seen, stray, timeout, quiet;
      logic [15:0] first_a, last_a;

      bus.cpu_a_in    = 16'h0000;
      bus.cpu_r_nw_in = 1'b1;
      bus.cpu_d_in    = 8'h00;

      // Reset values
      nrst = 1'b0;
      #1;
      check_reset_outputs("t1_rst");
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_eq("t1_idle.rdy",    bus.rdy_out,    1'b1);
      check_eq("t1_idle.ri_ncs", bus.ri_ncs_out, 1'b1);

      // Page 02 copy
      do_xfer("t2_p02", 8'h02, 1, 0);

      // Page FF must stay within FF00-FFFF
      do_xfer("t3_pFF", 8'hFF, 1, 0);

      // Held hit gives a single run; a fresh write afterwards starts another
      do_xfer("t4_hold", 8'h07, 600, 0);
      do_xfer("t4_p03",  8'h03, 1, 0);

      // Reset after the 100th strobe
      run_xfer(8'h04, 1, 100, rdy_low, exp_low, strobes, bad, first_a, last_a, zero_seen,
               stray, timeout);
      check_eq("t5_abort.timeout", timeout, 0);
      check_eq("t5_abort.bad",     bad,     0);
      nrst = 1'b0;
      #1;
      check_reset_outputs("t5_rst");
      quiet = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i == 4) nrst = 1'b1;
         if (!bus.ri_ncs_out || !bus.rdy_out || bus.dma_active_out) quiet++;
      end
      check_eq("t5_post_rst.activity", quiet, 0);
      do_xfer("t5_p01", 8'h01, 1, 0);

`ifdef OAM_DMA_ODD_ALIGN_EN
      // Start seen on odd parity in ALIGN, then on even parity
      while (tb_par !== 1'b0) @(negedge clk);
      do_xfer("t6_odd", 8'h05, 1, 514);
      while (tb_par !== 1'b1) @(negedge clk);
      do_xfer("t6_even", 8'h06, 1, 513);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
